// File: rtl/dm_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dm_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      ACK  = 1'b1
   } state_e;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_DBG = 1'b1;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 32;
   localparam int MEM_AW_DEF = 8;

endpackage

// File: rtl/dm_arb_if.sv
// Requester and memory-port bundle. The master side is the requesters plus the memory;
// the slave side is the arbiter.
interface dm_arb_if
   import dm_arb_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
);
   logic              req0;
   logic              we0;
   logic [ADDR_W-1:0] addr0;
   logic [DATA_W-1:0] wdata0;
   logic              ack0;
   logic [DATA_W-1:0] rdata0;
   logic              err0;

   logic              req1;
   logic              we1;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata1;
   logic              ack1;
   logic [DATA_W-1:0] rdata1;
   logic              err1;

   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wd;
   logic              mem_wrEn;
   logic [DATA_W-1:0] mem_rd;

   modport master (
      output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rd,
      input  ack0, rdata0, err0, ack1, rdata1, err1, mem_addr, mem_wd, mem_wrEn
   );

   modport slave (
      input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rd,
      output ack0, rdata0, err0, ack1, rdata1, err1, mem_addr, mem_wd, mem_wrEn
   );
endinterface

// File: rtl/dm_arb_rr_arb2.sv
// Two-way round-robin picker: on a tie the requester that did not win last time goes.
module rr_arb2
   import dm_arb_pkg::*;
(
   input  logic req0_i,
   input  logic req1_i,
   input  logic last_i,
   output logic gnt_valid_o,
   output logic gnt_idx_o
);
   assign gnt_valid_o = req0_i | req1_i;
   assign gnt_idx_o   = (req0_i & req1_i) ? ~last_i : (req1_i ? REQ_DBG : REQ_CPU);
endmodule

// File: rtl/dm_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the single-port data memory.
// Optional address checking is enabled by defining DM_ARB_ALIGN_CHECK_EN.
module dm_arbiter
   import dm_arb_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int MEM_AW = MEM_AW_DEF
) (
   input  logic    clk,
   input  logic    rst,
   dm_arb_if.slave bus
);
   logic [1:0]        req_v;
   logic [1:0]        we_v;
   logic [ADDR_W-1:0] addr_v  [2];
   logic [DATA_W-1:0] wdata_v [2];
   logic [1:0]        ack_v;
   logic [1:0]        err_v;
   logic [DATA_W-1:0] rdata_v [2];

   state_e            state_q, state_d;
   logic              last_q, last_d;
   logic              arb_valid, gnt_idx, grant, addr_err;
   logic [ADDR_W-1:0] addr_sel;

   if (MEM_AW + 2 > ADDR_W) begin : g_cfg_check
      $error("dm_arbiter: MEM_AW + 2 exceeds ADDR_W");
   end

   assign req_v            = {bus.req1, bus.req0};
   assign we_v             = {bus.we1, bus.we0};
   assign addr_v[REQ_CPU]  = bus.addr0;
   assign addr_v[REQ_DBG]  = bus.addr1;
   assign wdata_v[REQ_CPU] = bus.wdata0;
   assign wdata_v[REQ_DBG] = bus.wdata1;

   rr_arb2 u_rr (
      .req0_i      (req_v[0]),
      .req1_i      (req_v[1]),
      .last_i      (last_q),
      .gnt_valid_o (arb_valid),
      .gnt_idx_o   (gnt_idx)
   );

   assign grant    = arb_valid && (state_q == IDLE);
   assign addr_sel = addr_v[gnt_idx];

`ifdef DM_ARB_ALIGN_CHECK_EN
   assign addr_err = (addr_sel[1:0] != 2'b00) || (addr_sel[ADDR_W-1:MEM_AW+2] != '0);
`else
   assign addr_err = 1'b0;
`endif

   // Memory port is only driven in the grant cycle; a reset edge cancels the write.
   always_comb begin
      bus.mem_addr  = '0;
      bus.mem_wd    = '0;
      bus.mem_wrEn  = 1'b0;
      if (grant) begin
         bus.mem_addr = addr_err ? '0 : addr_sel;
         bus.mem_wd   = wdata_v[gnt_idx];
         bus.mem_wrEn = we_v[gnt_idx] && !addr_err && !rst;
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (grant) begin
               state_d = ACK;
               last_d  = gnt_idx;
            end
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= REQ_DBG;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_req
      localparam logic IDX = 1'(gi);
      logic              hit;
      logic              ack_q;
      logic              err_q;
      logic [DATA_W-1:0] rdata_q;

      assign hit = grant && (gnt_idx == IDX);

      // rdata is only reloaded on a grant to this requester, so it holds between accesses.
      always_ff @(posedge clk) begin
         if (rst) begin
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
         end else begin
            ack_q <= hit;
            err_q <= hit && addr_err;
            if (hit) begin
               rdata_q <= (we_v[gi] || addr_err) ? '0 : bus.mem_rd;
            end
         end
      end

      assign ack_v[gi]   = ack_q;
      assign err_v[gi]   = err_q;
      assign rdata_v[gi] = rdata_q;
   end

   assign bus.ack0   = ack_v[REQ_CPU];
   assign bus.ack1   = ack_v[REQ_DBG];
   assign bus.err0   = err_v[REQ_CPU];
   assign bus.err1   = err_v[REQ_DBG];
   assign bus.rdata0 = rdata_v[REQ_CPU];
   assign bus.rdata1 = rdata_v[REQ_DBG];

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: transaction-level reference model checked every
// cycle, plus directed vectors with literal expectations.
module tb_dm_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   dm_arb_if bus ();

   dm_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Memory behind the arbiter: combinational read, write on posedge.
   logic [31:0] mem   [256];
   logic [31:0] m_mem [256];

   assign bus.mem_rd = mem[bus.mem_addr[9:2]];

   always @(posedge clk) begin
      if (bus.mem_wrEn) mem[bus.mem_addr[9:2]] = bus.mem_wd;
   end

   function automatic logic [31:0] init_val(int i);
      if (i == 2) return 32'hDEADBEEF;
      if (i == 8) return 32'h0BADF00D;
      return 32'hC0DE0000 + 32'(i);
   endfunction

   function automatic logic addr_bad(logic [31:0] a);
`ifdef DM_ARB_ALIGN_CHECK_EN
      return (a[1:0] != 2'b00) || ((a >> 10) != 0);
`else
      return 1'b0;
`endif
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one transaction per grant, a busy response cycle after each grant.
   logic        m_live = 1'b0;
   logic        m_busy;
   logic        m_last;
   logic [1:0]  m_ack;
   logic [1:0]  m_err;
   logic [31:0] m_rdata [2];

   always @(negedge clk) begin
      logic [1:0]  r;
      logic        gv, w, e, we;
      logic [31:0] a, wd;
      r  = {bus.req1, bus.req0};
      gv = !m_busy && (r != 2'b00);
      w  = (r == 2'b11) ? !m_last : r[1];
      a  = w ? bus.addr1 : bus.addr0;
      wd = w ? bus.wdata1 : bus.wdata0;
      we = w ? bus.we1 : bus.we0;
      e  = gv && addr_bad(a);
      if (m_live) begin
         check("m_wrEn", bus.mem_wrEn, gv && we && !e && !rst);
         if (!rst) begin
            check("m_addr", bus.mem_addr, gv ? (e ? 32'h0 : a) : 32'h0);
            check("m_wd", bus.mem_wd, gv ? wd : 32'h0);
         end
         check("m_ack0", bus.ack0, m_ack[0]);
         check("m_ack1", bus.ack1, m_ack[1]);
         check("m_err0", bus.err0, m_err[0]);
         check("m_err1", bus.err1, m_err[1]);
         check("m_rdata0", bus.rdata0, m_rdata[0]);
         check("m_rdata1", bus.rdata1, m_rdata[1]);
      end
      if (rst) begin
         m_live = 1'b1;
         m_busy = 1'b0;
         m_last = 1'b1;
         m_ack  = 2'b00;
         m_err  = 2'b00;
         m_rdata[0] = '0;
         m_rdata[1] = '0;
      end else if (gv) begin
         if (we && !e) m_mem[a[9:2]] = wd;
         m_rdata[w] = (we || e) ? 32'h0 : m_mem[a[9:2]];
         m_ack      = w ? 2'b10 : 2'b01;
         m_err      = e ? m_ack : 2'b00;
         m_last     = w;
         m_busy     = 1'b1;
      end else begin
         m_busy = 1'b0;
         m_ack  = 2'b00;
         m_err  = 2'b00;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // Expected ack pattern for both requesters held high out of reset.
   logic [7:0] exp_a0 = 8'b0001_0001;
   logic [7:0] exp_a1 = 8'b0100_0100;

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]   = init_val(i);
         m_mem[i] = init_val(i);
      end
      bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
      bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
      step(); step();
      rst = 1'b0;
      check("rst_ack0", bus.ack0, 0);
      check("rst_ack1", bus.ack1, 0);
      check("rst_rdata0", bus.rdata0, 0);
      check("rst_wrEn", bus.mem_wrEn, 0);

      // Uncontended read
      bus.req0 = 1; bus.we0 = 0; bus.addr0 = 32'h8;
      step();
      check("rd_ack0", bus.ack0, 1);
      check("rd_ack1", bus.ack1, 0);
      check("rd_rdata0", bus.rdata0, 32'hDEADBEEF);
      bus.req0 = 0;
      step();
      check("rd_ack0_clr", bus.ack0, 0);
      check("rd_rdata0_hold", bus.rdata0, 32'hDEADBEEF);

      // Write by CPU then read back by debug port
      bus.req0 = 1; bus.we0 = 1; bus.addr0 = 32'h10; bus.wdata0 = 32'h12345678;
      #1;
      check("wr_wrEn_grant", bus.mem_wrEn, 1);
      step();
      check("wr_wrEn_ack", bus.mem_wrEn, 0);
      check("wr_ack0", bus.ack0, 1);
      check("wr_rdata0", bus.rdata0, 0);
      bus.req0 = 0; bus.we0 = 0;
      bus.req1 = 1; bus.we1 = 0; bus.addr1 = 32'h10;
      step(); step();
      check("rb_ack1", bus.ack1, 1);
      check("rb_rdata1", bus.rdata1, 32'h12345678);
      bus.req1 = 0;
      step();

      // Contention from reset
      rst = 1;
      bus.req0 = 1; bus.we0 = 0; bus.addr0 = 32'h8;
      bus.req1 = 1; bus.we1 = 0; bus.addr1 = 32'h10;
      step(); step();
      rst = 0;
      for (int k = 0; k < 8; k++) begin
         step();
         check("rr_ack0", bus.ack0, exp_a0[k]);
         check("rr_ack1", bus.ack1, exp_a1[k]);
      end
      check("rr_rdata0", bus.rdata0, 32'hDEADBEEF);
      check("rr_rdata1", bus.rdata1, 32'h12345678);

      // Write suppressed by reset in its grant cycle
      rst = 1;
      bus.req0 = 0;
      bus.req1 = 1; bus.we1 = 1; bus.addr1 = 32'h20; bus.wdata1 = 32'hA5A5A5A5;
      #1;
      check("rw_wrEn", bus.mem_wrEn, 0);
      step();
      check("rw_ack1", bus.ack1, 0);
      rst = 0; bus.req1 = 0; bus.we1 = 0;
      step();
      bus.req1 = 1; bus.we1 = 0; bus.addr1 = 32'h20;
      step();
      check("rw_rd_ack1", bus.ack1, 1);
      check("rw_rd_rdata1", bus.rdata1, 32'h0BADF00D);
      bus.req1 = 0;
      step();

      // Misaligned / out-of-range address
      bus.req0 = 1; bus.we0 = 1; bus.addr0 = 32'h402; bus.wdata0 = 32'hFFFFFFFF;
      #1;
`ifdef DM_ARB_ALIGN_CHECK_EN
      check("al_wrEn", bus.mem_wrEn, 0);
`else
      check("al_wrEn", bus.mem_wrEn, 1);
`endif
      step();
      check("al_ack0", bus.ack0, 1);
`ifdef DM_ARB_ALIGN_CHECK_EN
      check("al_err0", bus.err0, 1);
`else
      check("al_err0", bus.err0, 0);
`endif
      check("al_rdata0", bus.rdata0, 0);
      bus.req0 = 0; bus.we0 = 0;
      step();
      bus.req0 = 1; bus.addr0 = 32'h0;
      step();
      check("al_rd_err0", bus.err0, 0);
`ifdef DM_ARB_ALIGN_CHECK_EN
      check("al_rd_rdata0", bus.rdata0, 32'hC0DE0000);
`else
      check("al_rd_rdata0", bus.rdata0, 32'hFFFFFFFF);
`endif
      bus.req0 = 0;
      step(); step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
